// File: rtl/uart_tx_pkg.sv
// ============================================================
// uart_tx_pkg : shared state encoding and parity constants
// Rev 1.0
// ============================================================
`default_nettype none

package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/parity_calc.sv
// ============================================================
// parity_calc : combinational even/odd parity of a data word
// Rev 1.0
// ============================================================
`default_nettype none

import uart_tx_pkg::*;

module parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_o
);

  logic xor_all;

  assign xor_all = ^data_i;
  assign par_o   = (par_typ_i == PAR_ODD) ? ~xor_all : xor_all;

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// ============================================================
// uart_tx_ctrl : UART frame controller driving an external serializer
// Rev 1.0
// ============================================================
`default_nettype none

import uart_tx_pkg::*;

module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  output logic                  ser_load,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  busy_q;
  logic                  accept;
  logic                  par_bit;

  // RST gates accept so ser_load stays low while reset is held
  assign accept = RST & Data_Valid & ((state_q == IDLE) || (state_q == STOP));

  parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .data_i    (data_q),
    .par_typ_i (par_typ_q),
    .par_o     (par_bit)
  );

  // State register plus the counter, latches and registered Busy
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      if (accept) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE:   if (accept) state_d = START;
      START:  state_d = DATA;
      DATA: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: state_d = STOP;
      STOP:   state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // TX_OUT depends only on registered state, never on Data_Valid
  always_comb begin
    ser_load = accept;
    TX_OUT   = 1'b1;
    case (state_q)
      START:   TX_OUT = 1'b0;
      DATA:    TX_OUT = ser_data;
      PARITY:  TX_OUT = par_bit;
      default: TX_OUT = 1'b1;
    endcase
  end

  assign Busy = busy_q;

endmodule

`default_nettype wire

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the frame data bits and the P_DATA width.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 3, giving the bit-counter width, which is clog2(DATA_WIDTH).
REQ-003 The module SHALL have port CLK, input, 1 bit: the single clock, one serial bit per cycle.
REQ-004 The module SHALL have port RST, input, 1 bit: asynchronous active-low reset.
REQ-005 The module SHALL have port P_DATA, input, DATA_WIDTH bits: the parallel word offered for transmission.
REQ-006 The module SHALL have port Data_Valid, input, 1 bit: P_DATA is valid this cycle.
REQ-007 The module SHALL have port PAR_EN, input, 1 bit: append a parity bit.
REQ-008 The module SHALL have port PAR_TYP, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-009 The module SHALL have port ser_data, input, 1 bit: the serial bit returned by the downstream serializer.
REQ-010 The module SHALL have port ser_load, output, 1 bit: load strobe to the serializer, which drives its Load_Data_en.
REQ-011 The module SHALL have port TX_OUT, output, 1 bit: the UART line.
REQ-012 The module SHALL have port Busy, output, 1 bit: a frame is in progress.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-014 An accept SHALL occur when Data_Valid=1 in IDLE, or Data_Valid=1 in STOP; the second case is a back-to-back frame.
REQ-015 On accept, the block SHALL latch P_DATA, PAR_EN and PAR_TYP, and the next state SHALL be START.
REQ-016 ser_load SHALL be combinational and equal to 1 exactly in accept cycles, 0 otherwise.
REQ-017 The block SHALL use ser_load timing so that the serializer presents data bit k on ser_data during DATA cycle k, LSB first.
REQ-018 START SHALL last 1 cycle with TX_OUT=0, then go to DATA with the bit counter at 0.
REQ-019 DATA SHALL last DATA_WIDTH cycles with TX_OUT=ser_data, and the counter SHALL increment once per cycle.
REQ-020 At count DATA_WIDTH-1 the FSM SHALL go to PARITY when the latched PAR_EN=1, else to STOP.
REQ-021 PARITY SHALL last 1 cycle with TX_OUT equal to the XOR of the latched data when PAR_TYP=0, and its inverse when PAR_TYP=1.
REQ-022 The parity value SHALL be computed from the latched word, never from ser_data.
REQ-023 STOP SHALL last 1 cycle with TX_OUT=1, then go to START on accept, else to IDLE.
REQ-024 In IDLE, TX_OUT SHALL be 1.
REQ-025 Busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE; Busy SHALL be a registered output.
REQ-026 TX_OUT SHALL be a combinational mux selected by the state register, with no combinational path from Data_Valid.
REQ-027 Data_Valid in START, DATA or PARITY SHALL be ignored: no load, no state change, and the word is dropped.
REQ-028 Changes on P_DATA, PAR_EN or PAR_TYP mid-frame SHALL not affect the frame in progress.
REQ-029 Frame length SHALL be DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 cycles with parity.

Reset
REQ-030 While RST=0, regardless of CLK, the state SHALL be IDLE, with counter=0, latched data=0, latched PAR_EN=0, latched PAR_TYP=0, Busy=0, TX_OUT=1 and ser_load=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; the line returns to 1 and no partial bits follow release.
REQ-032 After RST release, the first accept SHALL be possible in the first clock cycle.

Structure
REQ-033 A package uart_tx_pkg SHALL hold the state enumeration (binary encoded) and the constants PAR_EVEN=0 and PAR_ODD=1.
REQ-034 A single sub-module parity_calc SHALL take a DATA_WIDTH-bit word and PAR_TYP and produce the parity bit combinationally.
REQ-035 The FSM, bit counter and latches SHALL be in uart_tx_ctrl.

Verification
REQ-036 The bench SHALL send P_DATA=0xA5 with PAR_EN=0 and check TX_OUT over 10 cycles = 0,1,0,1,0,0,1,0,1,1, with Busy high exactly 10 cycles.
REQ-037 The bench SHALL send 0xA5 with PAR_EN=1: PAR_TYP=0 gives parity bit 0 and PAR_TYP=1 gives parity bit 1, each in an 11-cycle frame.
REQ-038 The bench SHALL hold Data_Valid=1 during STOP with P_DATA=0x3C and check that START follows STOP with no idle cycle, with data bits 0,0,1,1,1,1,0,0.
REQ-039 The bench SHALL pulse Data_Valid with 0xFF during DATA cycle 3 of a 0x00 frame and check that the frame stays all zeros, no ser_load occurs, and IDLE follows STOP.
REQ-040 The bench SHALL drop RST during DATA cycle 4 and check that TX_OUT=1, Busy=0 and the state is IDLE asynchronously, and that a new 0x81 frame after release is correct.
REQ-041 The bench SHALL change PAR_TYP mid-frame and check that the parity bit uses the value latched at accept.
